spi_frame_rx: RTL and testbench



---
 rtl/spi_frame_pkg.sv | 31 +++
 rtl/spi_frame_rx_sync_edge.sv | 32 +++
 rtl/spi_frame_rx.sv | 156 +++++++++++++++
 tb/tb_spi_frame_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants, FSM state type and frame field helpers for the SPI
// register-write receiver.
package spi_frame_pkg;

  localparam int          FRAME_BITS = 16;
  localparam int          ADDR_W     = 7;
  localparam int          DATA_W     = 8;
  localparam int          CNT_W      = 5;
  localparam logic        RW_WRITE   = 1'b1;
  // One past a full frame, so an overlong frame can never alias to 16 bits.
  localparam logic [CNT_W-1:0] CNT_SAT = 5'd17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  function automatic logic frame_rw(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-1];
  endfunction

  function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-2 -: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_BITS-1:0] frame);
    return frame[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall detection
// against one further registered copy of the synchronised level.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 write-frame receiver: synchronises SCLK/COPI/nCS, shifts 16-bit
// MSB-first frames and strobes validated register writes.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_MAX    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_MAX);
  // Pin order: 0 = sclk, 1 = copi, 2 = ncs; ncs idles high.
  localparam logic [2:0] PIN_RST = 3'b100;

  logic [2:0] pin_raw;
  logic [2:0] pin_level;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;

  assign pin_raw = {ncs, copi, sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pin
      sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (PIN_RST[gi])
      ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pin_raw[gi]),
        .level(pin_level[gi]),
        .rise (pin_rise[gi]),
        .fall (pin_fall[gi])
      );
    end
  endgenerate

  logic sclk_rise;
  logic copi_level;
  logic ncs_level;
  logic ncs_rise;
  logic ncs_fall;

  assign sclk_rise  = pin_rise[0];
  assign copi_level = pin_level[1];
  assign ncs_level  = pin_level[2];
  assign ncs_rise   = pin_rise[2];
  assign ncs_fall   = pin_fall[2];

  // The remaining detector outputs have no consumer.
  logic unused_pins;
  assign unused_pins = &{1'b0, pin_level[0], pin_rise[1], pin_fall[1], pin_fall[0]};

  state_t                  state_reg, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic                    wr_valid_reg, wr_valid_next;
  logic                    frame_err_reg, frame_err_next;
  logic [ADDR_W-1:0]       addr_reg, addr_next;
  logic [DATA_W-1:0]       data_reg, data_next;
  logic                    busy_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      wr_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      count_reg     <= count_next;
      wr_valid_reg  <= wr_valid_next;
      frame_err_reg <= frame_err_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      busy_reg      <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    count_next     = count_reg;
    wr_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    addr_next      = addr_reg;
    data_next      = data_reg;

    case (state_reg)
      IDLE: begin
        if (ncs_fall) begin
          shift_next = '0;
          count_next = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (ncs_rise) begin
          state_next = CHECK;
        end else if (sclk_rise && !ncs_level) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], copi_level};
          if (count_reg != CNT_SAT) begin
            count_next = count_reg + 5'd1;
          end
        end
      end

      CHECK: begin
        if (count_reg == CNT_W'(FRAME_BITS)) begin
          // Reads and out-of-range addresses are dropped without any pulse.
          if (frame_rw(shift_reg) == RW_WRITE && frame_addr(shift_reg) <= ADDR_LIMIT) begin
            wr_valid_next = 1'b1;
            addr_next     = frame_addr(shift_reg);
            data_next     = frame_data(shift_reg);
          end
        end else begin
          frame_err_next = 1'b1;
        end
        state_next = IDLE;
        if (ncs_fall) begin
          shift_next = '0;
          count_next = '0;
          state_next = SHIFT;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign wr_valid  = wr_valid_reg;
  assign frame_err = frame_err_reg;
  assign wr_addr   = addr_reg;
  assign wr_data   = data_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: directed SPI frames push expected pulses,
// a concurrent monitor pops and checks them as the DUT strobes.
module tb_spi_frame_rx;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  spi_frame_rx #(.SYNC_STAGES(SYNC), .ADDR_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .copi     (copi),
    .ncs      (ncs),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [6:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [16:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_cyc(4);
      sclk = 1'b1;
      wait_cyc(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [16:0] bits, input int n, output int rise_cyc);
    ncs = 1'b0;
    wait_cyc(4);
    shift_bits(bits, n);
    wait_cyc(4);
    ncs = 1'b1;
    rise_cyc = cyc;
    $display("frame 0x%05h (%0d bits) sent, ncs rise at cycle %0d", bits, n, rise_cyc);
  endtask

  task automatic push_write(input logic [6:0] a, input logic [7:0] d, input int rc);
    exp_t e;
    e.is_err = 1'b0; e.addr = a; e.data = d; e.cyc = rc + LAT;
    sb.push_back(e);
    last_addr = a;
    last_data = d;
  endtask

  task automatic push_err(input int rc);
    exp_t e;
    e.is_err = 1'b1; e.addr = '0; e.data = '0; e.cyc = rc + LAT;
    sb.push_back(e);
  endtask

  // Let the pulse land, then confirm the FSM has gone idle and outputs hold.
  task automatic settle(input string tag);
    wait_cyc(8);
    check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_addr_hold"}, {25'b0, wr_addr}, {25'b0, last_addr});
    check({tag, "_data_hold"}, {24'b0, wr_data}, {24'b0, last_data});
  endtask

  initial begin
    int rc;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    wait_cyc(5);
    check("rst_wr_valid",  {31'b0, wr_valid},  32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_wr_addr",   {25'b0, wr_addr},   32'd0);
    check("rst_wr_data",   {24'b0, wr_data},   32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    fork
      begin : stim
        send(17'h08255, 16, rc); push_write(7'h02, 8'h55, rc); settle("write_8255");
        send(17'h00255, 16, rc); settle("read_0255");
        send(17'h085AA, 16, rc); settle("range_85AA");
        send(17'h084F0, 16, rc); push_write(7'h04, 8'hF0, rc); settle("write_84F0");
        send(17'h04255, 15, rc); push_err(rc); settle("len15");
        // Last 16 of these 17 bits would be a valid write to addr 2.
        send(17'h18255, 17, rc); push_err(rc); settle("len17");
        send(17'h08377, 16, rc); push_write(7'h03, 8'h77, rc); settle("write_8377");

        ncs = 1'b0;
        wait_cyc(4);
        shift_bits(17'h00081, 8);
        rst_n = 1'b0;
        wait_cyc(3);
        last_addr = '0;
        last_data = '0;
        check("midrst_busy", {31'b0, busy},    32'd0);
        check("midrst_addr", {25'b0, wr_addr}, 32'd0);
        check("midrst_data", {24'b0, wr_data}, 32'd0);
        rst_n = 1'b1;
        $display("reset pulsed mid-frame at cycle %0d, ncs held low", cyc);
        wait_cyc(4);
        shift_bits(17'h00033, 8);
        wait_cyc(4);
        ncs = 1'b1;
        rc = cyc;
        $display("partial frame after reset ends, ncs rise at cycle %0d", rc);
        push_err(rc);
        settle("midrst");
        send(17'h08101, 16, rc); push_write(7'h01, 8'h01, rc); settle("write_8101");

        send(17'h08011, 16, rc); push_write(7'h00, 8'h11, rc);
        wait_cyc(SYNC + 2);
        send(17'h08122, 16, rc); push_write(7'h01, 8'h22, rc); settle("b2b");
        wait_cyc(10);
      end
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n && (wr_valid || frame_err)) begin
            $display("pulse at cycle %0d: wr_valid=%0b frame_err=%0b addr=0x%02h data=0x%02h",
                     cyc, wr_valid, frame_err, wr_addr, wr_data);
            check("pulse_exclusive", {31'b0, wr_valid & frame_err}, 32'd0);
            if (sb.size() == 0) begin
              check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check("pulse_latency", cyc, e.cyc);
              check("pulse_is_err",  {31'b0, frame_err}, {31'b0, e.is_err});
              check("pulse_is_wr",   {31'b0, wr_valid},  {31'b0, ~e.is_err});
              if (!e.is_err) begin
                check("wr_addr", {25'b0, wr_addr}, {25'b0, e.addr});
                check("wr_data", {24'b0, wr_data}, {24'b0, e.data});
              end
            end
          end
        end
      end
    join_any
    disable fork;

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
